pc: RTL and testbench

- Program-counter register for the single-cycle MIPS datapath.
- Holds the address of the current instruction and drives the instruction-memory address.
- Loads a new address (PC+4, branch or jump target, selected upstream) when load-enabled.
- Otherwise holds its value; synchronous reset returns it to the reset vector.

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc.sv | 40 ++++
 tb/tb_pc.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: program-counter width, reset vector and
// the instruction-alignment helper used by the optional PC alignment check.
package mips_pkg;

  localparam int PC_WIDTH         = 32;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VAL = 32'h0000_0000;
  localparam int INSTR_ALIGN_BITS = 2;

  // True when an address is not on a word (instruction) boundary.
  function automatic logic is_misaligned(input logic [INSTR_ALIGN_BITS-1:0] low_bits);
    return low_bits != '0;
  endfunction

endpackage

// File: rtl/pc.sv
// Program-counter register: enabled load, synchronous active-high reset.
// Define PC_ALIGN_CHECK_EN to add the registered Misaligned flag.
module pc
  import mips_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = PC_RESET_VAL
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             LdEn,
  output logic [WIDTH-1:0] Dout
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             Misaligned
`endif
);

  // NOTE: state uses non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Dout <= RESET_VAL;
    end else if (LdEn) begin
      Dout <= Data;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Flag follows the same reset/load/hold priority as Dout; the address is still loaded.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Misaligned <= 1'b0;
    end else if (LdEn) begin
      Misaligned <= is_misaligned(Data[INSTR_ALIGN_BITS-1:0]);
    end
  end
`endif

endmodule

// File: tb/tb_pc.sv
// Directed self-checking bench for the pc register; the alignment-flag
// scenario is compiled in only when PC_ALIGN_CHECK_EN is defined.
module tb_pc;

  localparam int W = 32;

  logic         Clk;
  logic         Reset;
  logic [W-1:0] Data;
  logic         LdEn;
  logic [W-1:0] Dout;
`ifdef PC_ALIGN_CHECK_EN
  logic         Misaligned;
`endif

  int errors;
  int checks;

  pc #(.WIDTH(W), .RESET_VAL(32'h0000_0000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Data  (Data),
    .LdEn  (LdEn),
    .Dout  (Dout)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .Misaligned (Misaligned)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_dout(input string name, input logic [W-1:0] exp);
    checks++;
    if (Dout !== exp) begin
      errors++;
      $display("FAIL %s: Dout=%h expected %h", name, Dout, exp);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; LdEn = 1'b0; Data = 32'h1234_5678;
    step();
    expect_dout("reset_vector", 32'h0);
    Data = 32'hDEAD_BEEF; LdEn = 1'b1;
    step();
    expect_dout("reset_held_ignores_data", 32'h0);
  endtask

  task automatic test_load_hold();
    Reset = 1'b0; LdEn = 1'b0; Data = 32'd31;
    step();
    expect_dout("idle_edge1", 32'h0);
    step();
    expect_dout("idle_edge2", 32'h0);
    LdEn = 1'b1;
    step();
    expect_dout("load_31", 32'd31);
    step();
    expect_dout("reload_31_stable_a", 32'd31);
    step();
    expect_dout("reload_31_stable_b", 32'd31);
  endtask

  task automatic test_reset_override();
    Reset = 1'b1; LdEn = 1'b1; Data = 32'd31;
    step();
    expect_dout("reset_over_load", 32'h0);
    Data = 32'd2;
    step();
    expect_dout("reset_over_data2", 32'h0);
  endtask

  task automatic test_release_hold();
    Reset = 1'b0; LdEn = 1'b0; Data = 32'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_dout($sformatf("post_reset_hold_%0d", i), 32'h0);
    end
    LdEn = 1'b1;
    step();
    expect_dout("load_2", 32'd2);
  endtask

  task automatic test_all_ones_hold();
    LdEn = 1'b1; Data = 32'hFFFF_FFFC;
    step();
    expect_dout("load_fffffffc", 32'hFFFF_FFFC);
    LdEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Data = $urandom();
      step();
      expect_dout($sformatf("hold_fffffffc_%0d", i), 32'hFFFF_FFFC);
    end
    LdEn = 1'b1; Data = 32'hFFFF_FFFF;
    step();
    expect_dout("load_all_ones", 32'hFFFF_FFFF);
  endtask

  task automatic test_mid_cycle();
    LdEn = 1'b0; Data = 32'h0000_0040;
    #2;
    expect_dout("no_comb_data_path", 32'hFFFF_FFFF);
    LdEn = 1'b1;
    #2;
    expect_dout("no_comb_lden_path", 32'hFFFF_FFFF);
    Reset = 1'b1;
    #1;
    expect_dout("no_comb_reset_path", 32'hFFFF_FFFF);
    Reset = 1'b0;
    step();
    expect_dout("load_at_edge_only", 32'h0000_0040);
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic expect_mis(input string name, input logic exp);
    checks++;
    if (Misaligned !== exp) begin
      errors++;
      $display("FAIL %s: Misaligned=%b expected %b", name, Misaligned, exp);
    end
  endtask

  task automatic test_align();
    Reset = 1'b0; LdEn = 1'b1; Data = 32'd6;
    step();
    expect_dout("align_load_6", 32'd6);
    expect_mis("mis_after_6", 1'b1);
    LdEn = 1'b0; Data = 32'd8;
    step();
    expect_mis("mis_hold", 1'b1);
    LdEn = 1'b1;
    step();
    expect_mis("mis_after_8", 1'b0);
    Data = 32'd5;
    step();
    expect_mis("mis_after_5", 1'b1);
    Reset = 1'b1;
    step();
    expect_mis("mis_reset", 1'b0);
    expect_dout("align_reset_dout", 32'h0);
    Reset = 1'b0; LdEn = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    Reset = 1'b0; LdEn = 1'b0; Data = '0;
    #1;
    test_reset();
    test_load_hold();
    test_reset_override();
    test_release_hold();
    test_all_ones_hold();
    test_mid_cycle();
`ifdef PC_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
